// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy fire scheduler.
// State encoding, LFSR constants and screen geometry.
package enemy_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    PICK = 3'd2,
    FIRE = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam int COORD_W = 11;

  localparam logic [COORD_W-1:0] SCREEN_Y_MAX = 11'd767;

  // One Galois step, shifting right.
  function automatic logic [15:0] lfsr_step(
    input logic [15:0] cur
  );
    lfsr_step = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/enemy_fire_sched_lfsr16.sv
// Free-running 16-bit Galois LFSR, stepping every cycle.
// Used for shot jitter and shooter selection.
module lfsr16
  import enemy_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  output logic [15:0] q
);

  // Advance every cycle; reset reloads the seed.
  always_ff @(posedge pclk) begin
    if (rst) q <= LFSR_SEED;
    else     q <= lfsr_step(q);
  end

endmodule

// File: rtl/enemy_fire_sched.sv
// Enemy fire scheduler: picks a live shooter and pulses fire.
// Optional ENEMY_FIRE_RANDOM_EN adds LFSR jitter and random start.
module enemy_fire_sched
  import enemy_pkg::*;
#(
  parameter int N_ENEMIES    = 8,
  parameter int BASE_DELAY   = 32_500_000,
  parameter int JITTER_SHIFT = 8,
  parameter int X_OFFSET     = 24,
  parameter int Y_OFFSET     = 64,
  parameter int Y_MAX        = int'(SCREEN_Y_MAX),
  parameter int HOLD_TIMEOUT = 4
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     game_en,
  input  logic [N_ENEMIES-1:0]     enemy_alive,
  input  logic [11*N_ENEMIES-1:0]  enemy_xpos_flat,
  input  logic [11*N_ENEMIES-1:0]  enemy_ypos_flat,
  input  logic                     missile_on,
  output logic                     fire,
  output logic                     shooter_alive,
  output logic [COORD_W-1:0]       xpos_out,
  output logic [COORD_W-1:0]       ypos_out,
  output logic [3:0]               shooter_idx
);

  state_t state;
  state_t state_n;

  logic [25:0] delay_cnt;
  logic [25:0] jitter;
  logic [3:0]  start_idx;
  logic [3:0]  scan_idx;
  logic [3:0]  scan_nxt;
  logic [4:0]  scanned;
  logic [15:0] hold_cnt;

  logic        load_dly;
  logic        start_pick;
  logic        hit;

  logic [15:0]        alive_pad;
  logic [COORD_W-1:0] x_arr [16];
  logic [COORD_W-1:0] y_arr [16];

  logic [COORD_W-1:0] x_sel;
  logic [COORD_W-1:0] y_sel;
  logic [COORD_W-1:0] x_muz;
  logic [11:0]        y_sum;
  logic [COORD_W-1:0] y_muz;

  assign alive_pad = 16'(enemy_alive);

  genvar g;
  for (g = 0; g < 16; g++) begin : g_unpack
    if (g < N_ENEMIES) begin : g_live
      assign x_arr[g] = enemy_xpos_flat[11*g +: 11];
      assign y_arr[g] = enemy_ypos_flat[11*g +: 11];
    end else begin : g_pad
      assign x_arr[g] = '0;
      assign y_arr[g] = '0;
    end
  end

`ifdef ENEMY_FIRE_RANDOM_EN
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .pclk (pclk),
    .rst  (rst),
    .q    (lfsr_q)
  );

  assign jitter    = 26'(lfsr_q) << JITTER_SHIFT;
  assign start_idx = 4'(32'(lfsr_q[3:0]) % N_ENEMIES);
`else
  logic [3:0] rr_ptr;

  assign jitter    = '0;
  assign start_idx = rr_ptr;
`endif

  assign scan_nxt =
    (scan_idx == 4'(N_ENEMIES - 1)) ? 4'd0 : scan_idx + 4'd1;

  assign x_sel = x_arr[scan_idx];
  assign y_sel = y_arr[scan_idx];
  assign x_muz = x_sel + 11'(X_OFFSET);
  assign y_sum = {1'b0, y_sel} + 12'(Y_OFFSET);
  assign y_muz = (y_sum > 12'(Y_MAX)) ? 11'(Y_MAX) : y_sum[10:0];

  assign fire          = (state == FIRE);
  assign shooter_alive = (state == FIRE) || (state == HOLD);

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_n    = state;
    load_dly   = 1'b0;
    start_pick = 1'b0;
    hit        = 1'b0;
    case (state)
      IDLE: begin
        if (game_en && !missile_on) begin
          state_n  = WAIT;
          load_dly = 1'b1;
        end
      end
      WAIT: begin
        if (game_en && delay_cnt == '0) begin
          state_n    = PICK;
          start_pick = 1'b1;
        end
      end
      PICK: begin
        if (alive_pad[scan_idx]) begin
          state_n = FIRE;
          hit     = 1'b1;
        end else if (scanned == 5'(N_ENEMIES - 1)) begin
          state_n = IDLE;
        end
      end
      FIRE: state_n = HOLD;
      HOLD: begin
        if (missile_on ||
            hold_cnt == 16'(HOLD_TIMEOUT - 1))
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Delay counter: load on launch, count down only while gameplay runs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      delay_cnt <= '0;
    end else if (load_dly) begin
      delay_cnt <= 26'(BASE_DELAY - 1) + jitter;
    end else if (state == WAIT && game_en && delay_cnt != '0) begin
      delay_cnt <= delay_cnt - 26'd1;
    end
  end

  // Scan pointer and miss counter for the shooter search.
  always_ff @(posedge pclk) begin
    if (rst) begin
      scan_idx <= '0;
      scanned  <= '0;
    end else if (start_pick) begin
      scan_idx <= start_idx;
      scanned  <= '0;
    end else if (state == PICK && !hit) begin
      scan_idx <= scan_nxt;
      scanned  <= scanned + 5'd1;
    end
  end

  // Muzzle position and shooter latched on a hit, held until the next one.
  always_ff @(posedge pclk) begin
    if (rst) begin
      xpos_out    <= '0;
      ypos_out    <= '0;
      shooter_idx <= '0;
    end else if (hit) begin
      xpos_out    <= x_muz;
      ypos_out    <= y_muz;
      shooter_idx <= scan_idx;
    end
  end

`ifndef ENEMY_FIRE_RANDOM_EN
  // Round-robin start: one past the last shooter.
  always_ff @(posedge pclk) begin
    if (rst)      rr_ptr <= '0;
    else if (hit) rr_ptr <= scan_nxt;
  end
`endif

  // Cycles spent in HOLD waiting for the missile to launch.
  always_ff @(posedge pclk) begin
    if (rst)                hold_cnt <= '0;
    else if (state == FIRE) hold_cnt <= '0;
    else if (state == HOLD) hold_cnt <= hold_cnt + 16'd1;
  end

endmodule

// File: tb/tb_enemy_fire_sched.sv
// Directed bench for enemy_fire_sched, round-robin build.
// Cycle numbers count from the first cycle after reset release.
module tb_enemy_fire_sched;

  localparam int N  = 8;
  localparam int BD = 100;

  logic          pclk = 1'b0;
  logic          rst;
  logic          game_en;
  logic [N-1:0]  enemy_alive;
  logic [11*N-1:0] xf;
  logic [11*N-1:0] yf;
  logic          missile_on;
  logic          fire;
  logic          shooter_alive;
  logic [10:0]   xpos_out;
  logic [10:0]   ypos_out;
  logic [3:0]    shooter_idx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  enemy_fire_sched #(
    .N_ENEMIES  (N),
    .BASE_DELAY (BD)
  ) dut (
    .pclk            (pclk),
    .rst             (rst),
    .game_en         (game_en),
    .enemy_alive     (enemy_alive),
    .enemy_xpos_flat (xf),
    .enemy_ypos_flat (yf),
    .missile_on      (missile_on),
    .fire            (fire),
    .shooter_alive   (shooter_alive),
    .xpos_out        (xpos_out),
    .ypos_out        (ypos_out),
    .shooter_idx     (shooter_idx)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge pclk);
    rst = 1'b1;
    repeat (n) @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic set_enemy(input int i, input int x, input int y);
    xf[11*i +: 11] = 11'(x);
    yf[11*i +: 11] = 11'(y);
  endtask

  task automatic wait_fire(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge pclk);
      if (fire) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 2000 && cyc < c; i++) @(negedge pclk);
  endtask

  int at;
  int cnt_f;
  int cnt_a;

  initial begin
    rst         = 1'b1;
    game_en     = 1'b1;
    enemy_alive = '0;
    xf          = '0;
    yf          = '0;
    missile_on  = 1'b0;

    // reset values with everyone alive
    enemy_alive = 8'hFF;
    for (int i = 0; i < N; i++) set_enemy(i, 100 + i, 50 + i);
    do_reset(3);
    chk("rst_fire", 32'(fire), 0);
    chk("rst_sa", 32'(shooter_alive), 0);
    chk("rst_x", 32'(xpos_out), 0);
    chk("rst_y", 32'(ypos_out), 0);
    chk("rst_idx", 32'(shooter_idx), 0);
    cnt_f = 0;
    repeat (5) begin
      @(negedge pclk);
      if (fire) cnt_f++;
    end
    chk("rst_nofire5", 32'(cnt_f), 0);

    // round-robin: single live enemy 5
    enemy_alive = 8'b0010_0000;
    set_enemy(5, 300, 200);
    do_reset(2);
    wait_fire(300, at);
    chk("rr_cycle", 32'(at), 107);
    chk("rr_x", 32'(xpos_out), 324);
    chk("rr_y", 32'(ypos_out), 264);
    chk("rr_idx", 32'(shooter_idx), 5);
    chk("rr_sa", 32'(shooter_alive), 1);
    @(negedge pclk);
    chk("rr_pulse1", 32'(fire), 0);
    chk("rr_hold_sa", 32'(shooter_alive), 1);

    // y clamp on enemy 2, then round-robin continues from 3
    enemy_alive = 8'b0000_0100;
    set_enemy(2, 100, 740);
    set_enemy(1, 50, 10);
    do_reset(2);
    wait_fire(300, at);
    chk("clamp_cycle", 32'(at), 104);
    chk("clamp_y", 32'(ypos_out), 767);
    chk("clamp_x", 32'(xpos_out), 124);
    chk("clamp_idx", 32'(shooter_idx), 2);
    set_enemy(2, 0, 0);
    enemy_alive = 8'b0000_0110;
    @(negedge pclk);
    chk("latch_y_held", 32'(ypos_out), 767);
    chk("latch_x_held", 32'(xpos_out), 124);
    wait_fire(300, at);
    chk("rr2_cycle", 32'(at), 104 + 113);
    chk("rr2_idx", 32'(shooter_idx), 1);
    chk("rr2_x", 32'(xpos_out), 74);
    chk("rr2_y", 32'(ypos_out), 74);

    // all dead: never fires
    enemy_alive = '0;
    do_reset(2);
    cnt_f = 0;
    cnt_a = 0;
    repeat (1000) begin
      @(negedge pclk);
      if (fire) cnt_f++;
      if (shooter_alive) cnt_a++;
    end
    chk("dead_fire", 32'(cnt_f), 0);
    chk("dead_sa", 32'(cnt_a), 0);

    // missile in flight gates launch
    enemy_alive = 8'hFF;
    missile_on  = 1'b1;
    do_reset(2);
    cnt_f = 0;
    repeat (300) begin
      @(negedge pclk);
      if (fire) cnt_f++;
    end
    chk("mon_fire", 32'(cnt_f), 0);
    missile_on = 1'b0;

    // freeze during WAIT delays by exactly 50
    enemy_alive = 8'b0010_0000;
    set_enemy(5, 300, 200);
    do_reset(2);
    wait_cyc(20);
    game_en = 1'b0;
    repeat (50) @(negedge pclk);
    game_en = 1'b1;
    wait_fire(400, at);
    chk("freeze_cycle", 32'(at), 157);
    chk("freeze_idx", 32'(shooter_idx), 5);

    // reset mid-WAIT restarts count and rr pointer
    wait_cyc(200);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    chk("rst2_x", 32'(xpos_out), 0);
    wait_fire(300, at);
    chk("rst2_cycle", 32'(at), 107);
    chk("rst2_idx", 32'(shooter_idx), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
